// File: rtl/var_state_bank_if.sv
// rtl/var_state_bank_if.sv - request/status bundle between the variable state bank and its controller
//
// Purpose: groups every non-clock signal of var_state_bank.
// The master modport is the controller / solver side.
// The slave modport is the bank side.
// Port summary (names seen from the bank):
//   wr_i, var_value_i              load a full assignment (all levels become 0)
//   var_value_frombase_o           registered bank contents, 3 bits per variable {imp, val[1:0]}
//   var_value_tobase_i             clause evaluator feedback (implications / conflicts)
//   decide_i, decide_var_i, decide_val_i
//                                  decision request
//   apply_backtrack_i, bkt_lvl_i   backtrack request
//   busy_o, done_o                 propagating / propagation settled (pulse)
//   conflict_o, conflict_var_o     conflict state, lowest conflicting index
//   cur_lvl_o                      current decision level
//   reject_o                       refused request (pulse)
interface var_state_bank_if #(
  parameter int NUM_VARS_A_BIN = 8,
  parameter int WIDTH_LVL      = 4
);
  logic                          wr_i;
  logic [NUM_VARS_A_BIN*3-1:0]   var_value_i;
  logic [NUM_VARS_A_BIN*3-1:0]   var_value_frombase_o;
  logic [NUM_VARS_A_BIN*3-1:0]   var_value_tobase_i;
  logic                          decide_i;
  logic [2:0]                    decide_var_i;
  logic                          decide_val_i;
  logic                          apply_backtrack_i;
  logic [WIDTH_LVL-1:0]          bkt_lvl_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          conflict_o;
  logic [2:0]                    conflict_var_o;
  logic [WIDTH_LVL-1:0]          cur_lvl_o;
  logic                          reject_o;

  modport master (
    output wr_i, var_value_i, var_value_tobase_i,
    output decide_i, decide_var_i, decide_val_i,
    output apply_backtrack_i, bkt_lvl_i,
    input  var_value_frombase_o, busy_o, done_o,
    input  conflict_o, conflict_var_o, cur_lvl_o, reject_o
  );

  modport slave (
    input  wr_i, var_value_i, var_value_tobase_i,
    input  decide_i, decide_var_i, decide_val_i,
    input  apply_backtrack_i, bkt_lvl_i,
    output var_value_frombase_o, busy_o, done_o,
    output conflict_o, conflict_var_o, cur_lvl_o, reject_o
  );
endinterface

// File: rtl/var_state_bank.sv
// rtl/var_state_bank.sv - SAT variable assignment bank with decision levels, propagation merge and backtrack
//
// Purpose: holds NUM_VARS_A_BIN 3-bit variables {imp, val} plus a decision level per variable.
// It merges clause evaluator feedback until the assignment settles or conflicts.
// It also applies decisions and backtracks.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  var_state_bank_if.slave (see interface file for the signal list)
module var_state_bank #(
  parameter int NUM_VARS_A_BIN = 8,
  parameter int WIDTH_LVL      = 4
) (
  input  logic            clk,
  input  logic            rst,
  var_state_bank_if.slave bus
);
  localparam int NV = NUM_VARS_A_BIN;

  typedef enum logic [1:0] {S_IDLE, S_PROP, S_CONFLICT} state_t;

  state_t               state_q;
  logic [NV*3-1:0]      bank_q;
  logic [WIDTH_LVL-1:0] lvl_q [NV];
  logic [WIDTH_LVL-1:0] cur_lvl_q;
  logic                 done_q;
  logic                 reject_q;
  logic [2:0]           conflict_var_q;

  logic [NV-1:0]        adopt;
  logic [NV-1:0]        clash;
  logic [2:0]           first_conf;
  logic [1:0]           dec_cur;
  logic                 dec_ok;
  logic                 bkt_ok;

  // Per-variable merge of evaluator feedback against the bank.
  // Only the val field of the feedback matters; its imp bit is ignored.
  // A bank value of 11 (possible only via a load) is never treated as "assigned", so it cannot clash.
  always_comb begin
    adopt      = '0;
    clash      = '0;
    first_conf = '0;
    for (int i = 0; i < NV; i++) begin
      if (bus.var_value_tobase_i[3*i +: 2] == 2'b11) begin
        clash[i] = 1'b1;
      end else if (bus.var_value_tobase_i[3*i +: 2] != 2'b00) begin
        if (bank_q[3*i +: 2] == 2'b00) begin
          adopt[i] = 1'b1;
        end else if (bank_q[3*i +: 2] != 2'b11 &&
                     bank_q[3*i +: 2] != bus.var_value_tobase_i[3*i +: 2]) begin
          clash[i] = 1'b1;
        end
      end
    end
    // Scan downwards so the lowest clashing index wins.
    for (int i = NV - 1; i >= 0; i--) begin
      if (clash[i]) first_conf = 3'(i);
    end
  end

  assign dec_cur = bank_q[3*int'(bus.decide_var_i) +: 2];
  assign dec_ok  = (int'(bus.decide_var_i) < NV) && (dec_cur == 2'b00) && (cur_lvl_q != '1);
  assign bkt_ok  = (bus.bkt_lvl_i < cur_lvl_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bank_q         <= '0;
      cur_lvl_q      <= '0;
      done_q         <= 1'b0;
      reject_q       <= 1'b0;
      conflict_var_q <= '0;
      for (int i = 0; i < NV; i++) lvl_q[i] <= '0;
    end else begin
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      if (state_q == S_PROP) begin
        // Requests are refused while propagating; loads are silently ignored.
        if (bus.apply_backtrack_i || bus.decide_i) reject_q <= 1'b1;
        if (|clash) begin
          state_q        <= S_CONFLICT;
          conflict_var_q <= first_conf;
        end else if (|adopt) begin
          for (int i = 0; i < NV; i++) begin
            if (adopt[i]) begin
              bank_q[3*i +: 3] <= {1'b1, bus.var_value_tobase_i[3*i +: 2]};
              lvl_q[i]         <= cur_lvl_q;
            end
          end
        end else begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
      end else if (bus.apply_backtrack_i) begin
        if (bkt_ok) begin
          for (int i = 0; i < NV; i++) begin
            if (lvl_q[i] > bus.bkt_lvl_i) begin
              bank_q[3*i +: 3] <= 3'b000;
              lvl_q[i]         <= '0;
            end
          end
          cur_lvl_q      <= bus.bkt_lvl_i;
          conflict_var_q <= '0;
          state_q        <= S_PROP;
        end else begin
          reject_q <= 1'b1;
        end
      end else if (bus.decide_i) begin
        if (state_q == S_IDLE && dec_ok) begin
          bank_q[3*int'(bus.decide_var_i) +: 3] <= {1'b0, (bus.decide_val_i ? 2'b10 : 2'b01)};
          lvl_q[bus.decide_var_i]                <= cur_lvl_q + 1'b1;
          cur_lvl_q                              <= cur_lvl_q + 1'b1;
          state_q                                <= S_PROP;
        end else begin
          reject_q <= 1'b1;
        end
      end else if (bus.wr_i && state_q == S_IDLE) begin
        bank_q    <= bus.var_value_i;
        cur_lvl_q <= '0;
        for (int i = 0; i < NV; i++) lvl_q[i] <= '0;
        state_q   <= S_PROP;
      end
    end
  end

  assign bus.var_value_frombase_o = bank_q;
  assign bus.busy_o               = (state_q == S_PROP);
  assign bus.conflict_o           = (state_q == S_CONFLICT);
  assign bus.done_o               = done_q;
  assign bus.reject_o             = reject_q;
  assign bus.conflict_var_o       = conflict_var_q;
  assign bus.cur_lvl_o            = cur_lvl_q;
endmodule

// File: tb/tb_var_state_bank.sv
// tb/tb_var_state_bank.sv - directed self-checking bench for var_state_bank
module tb_var_state_bank;
  localparam int NV = 8;
  localparam int WL = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [NV*3-1:0] exp_bank;

  var_state_bank_if #(.NUM_VARS_A_BIN(NV), .WIDTH_LVL(WL)) bus ();

  var_state_bank #(.NUM_VARS_A_BIN(NV), .WIDTH_LVL(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.wr_i              = 1'b0;
    bus.decide_i          = 1'b0;
    bus.apply_backtrack_i = 1'b0;
  endtask

  task automatic decide(input int v, input logic val);
    bus.decide_i     = 1'b1;
    bus.decide_var_i = 3'(v);
    bus.decide_val_i = val;
  endtask

  task automatic backtrack(input int lvl);
    bus.apply_backtrack_i = 1'b1;
    bus.bkt_lvl_i         = WL'(lvl);
  endtask

  initial begin
    quiet();
    bus.var_value_i        = '0;
    bus.var_value_tobase_i = '0;
    bus.decide_var_i       = '0;
    bus.decide_val_i       = 1'b0;
    bus.bkt_lvl_i          = '0;

    // Reset state
    #2 rst = 1'b1;
    #2;
    check_eq("rst_busy",     32'(bus.busy_o), 0);
    check_eq("rst_done",     32'(bus.done_o), 0);
    check_eq("rst_conflict", 32'(bus.conflict_o), 0);
    check_eq("rst_cvar",     32'(bus.conflict_var_o), 0);
    check_eq("rst_lvl",      32'(bus.cur_lvl_o), 0);
    check_eq("rst_reject",   32'(bus.reject_o), 0);
    check_eq("rst_bank",     32'(bus.var_value_frombase_o), 0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Load all-free, settle
    bus.wr_i = 1'b1;
    step();
    check_eq("load_busy", 32'(bus.busy_o), 1);
    quiet();
    step();
    check_eq("load_done", 32'(bus.done_o), 1);
    check_eq("load_idle", 32'(bus.busy_o), 0);

    // Decide var 3 true, evaluator implies var 1 false; decide while busy is refused
    decide(3, 1'b1);
    step();
    check_eq("dec_lvl",  32'(bus.cur_lvl_o), 1);
    check_eq("dec_busy", 32'(bus.busy_o), 1);
    check_eq("dec_bank", 32'(bus.var_value_frombase_o), 32'h400);
    decide(6, 1'b1);
    bus.var_value_tobase_i = 24'h28;
    step();
    check_eq("busy_dec_reject", 32'(bus.reject_o), 1);
    check_eq("imp_adopt",       32'(bus.var_value_frombase_o), 32'h428);
    check_eq("imp_not_done",    32'(bus.done_o), 0);
    quiet();
    step();
    check_eq("settle_done",   32'(bus.done_o), 1);
    check_eq("settle_reject", 32'(bus.reject_o), 0);
    check_eq("settle_bank",   32'(bus.var_value_frombase_o), 32'h428);
    check_eq("settle_lvl",    32'(bus.cur_lvl_o), 1);

    // Decide on an already-assigned variable
    decide(1, 1'b0);
    step();
    check_eq("assigned_reject", 32'(bus.reject_o), 1);
    check_eq("assigned_bank",   32'(bus.var_value_frombase_o), 32'h428);
    check_eq("assigned_idle",   32'(bus.busy_o), 0);
    quiet();

    // Conflict on vars 3 and 5, lowest index reported and held
    bus.var_value_tobase_i = '0;
    bus.var_value_i        = '0;
    bus.wr_i               = 1'b1;
    step();
    quiet();
    step();
    check_eq("reload_lvl", 32'(bus.cur_lvl_o), 0);
    decide(3, 1'b1);
    step();
    quiet();
    bus.var_value_tobase_i = 24'h38E00;
    step();
    check_eq("conf_flag", 32'(bus.conflict_o), 1);
    check_eq("conf_var",  32'(bus.conflict_var_o), 3);
    check_eq("conf_bank", 32'(bus.var_value_frombase_o), 32'h400);
    check_eq("conf_busy", 32'(bus.busy_o), 0);
    decide(0, 1'b1);
    step();
    check_eq("conf_dec_reject", 32'(bus.reject_o), 1);
    check_eq("conf_hold_flag",  32'(bus.conflict_o), 1);
    check_eq("conf_hold_var",   32'(bus.conflict_var_o), 3);
    quiet();
    backtrack(1);
    step();
    check_eq("conf_bkt_eq_reject", 32'(bus.reject_o), 1);
    check_eq("conf_bkt_eq_hold",   32'(bus.conflict_o), 1);
    backtrack(0);
    bus.var_value_tobase_i = '0;
    step();
    check_eq("conf_bkt_flag", 32'(bus.conflict_o), 0);
    check_eq("conf_bkt_var",  32'(bus.conflict_var_o), 0);
    check_eq("conf_bkt_bank", 32'(bus.var_value_frombase_o), 0);
    check_eq("conf_bkt_lvl",  32'(bus.cur_lvl_o), 0);
    check_eq("conf_bkt_busy", 32'(bus.busy_o), 1);
    quiet();
    step();
    check_eq("conf_bkt_done", 32'(bus.done_o), 1);

    // Three levels with implications, then backtrack to level 1
    decide(0, 1'b1);
    step();
    quiet();
    bus.var_value_tobase_i = 24'h28;
    step();
    step();
    decide(2, 1'b0);
    step();
    quiet();
    bus.var_value_tobase_i = 24'h28 | 24'hC00;
    step();
    step();
    decide(4, 1'b1);
    step();
    quiet();
    bus.var_value_tobase_i = 24'h28 | 24'hC00 | 24'h28000;
    step();
    step();
    check_eq("lvl3_done", 32'(bus.done_o), 1);
    check_eq("lvl3_bank", 32'(bus.var_value_frombase_o), 32'h2AC6A);
    check_eq("lvl3_lvl",  32'(bus.cur_lvl_o), 3);
    backtrack(1);
    bus.var_value_tobase_i = 24'h28;
    step();
    check_eq("bkt1_bank", 32'(bus.var_value_frombase_o), 32'h2A);
    check_eq("bkt1_lvl",  32'(bus.cur_lvl_o), 1);
    check_eq("bkt1_busy", 32'(bus.busy_o), 1);
    quiet();
    step();
    check_eq("bkt1_done", 32'(bus.done_o), 1);

    // Decide and backtrack in the same idle cycle: backtrack wins, no reject
    bus.var_value_tobase_i = '0;
    decide(6, 1'b1);
    backtrack(0);
    step();
    check_eq("prio_reject", 32'(bus.reject_o), 0);
    check_eq("prio_bank",   32'(bus.var_value_frombase_o), 0);
    check_eq("prio_lvl",    32'(bus.cur_lvl_o), 0);
    check_eq("prio_busy",   32'(bus.busy_o), 1);
    quiet();
    step();
    backtrack(0);
    step();
    check_eq("bkt_ge_reject", 32'(bus.reject_o), 1);
    check_eq("bkt_ge_idle",   32'(bus.busy_o), 0);
    quiet();

    // Fill the level register to all-ones, then one more decision is refused
    exp_bank = '0;
    for (int k = 0; k < 7; k++) begin
      decide(k, 1'b1);
      step();
      quiet();
      step();
      exp_bank = exp_bank | ((NV*3)'(2) << (3*k));
    end
    check_eq("full_lvl",  32'(bus.cur_lvl_o), 7);
    check_eq("full_bank", 32'(bus.var_value_frombase_o), 32'(exp_bank));
    decide(7, 1'b1);
    step();
    check_eq("full_reject", 32'(bus.reject_o), 1);
    check_eq("full_bank2",  32'(bus.var_value_frombase_o), 32'(exp_bank));
    check_eq("full_idle",   32'(bus.busy_o), 0);
    quiet();

    // Reset in the middle of propagation
    backtrack(0);
    step();
    quiet();
    check_eq("prerst_busy", 32'(bus.busy_o), 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(bus.busy_o), 0);
    check_eq("midrst_bank", 32'(bus.var_value_frombase_o), 0);
    check_eq("midrst_lvl",  32'(bus.cur_lvl_o), 0);
    check_eq("midrst_done", 32'(bus.done_o), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    step();
    check_eq("postrst_done1", 32'(bus.done_o), 0);
    step();
    check_eq("postrst_done2", 32'(bus.done_o), 0);
    check_eq("postrst_busy",  32'(bus.busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
